// File: rtl/count_step_checker.sv
// Step checker for an up/down counter: verifies each sampled value is exactly one
// step from the previous sample, flags errors/wraps/direction changes, tracks lock.
module count_step_checker #(
  parameter int WIDTH  = 3,
  parameter int ERR_W  = 8,
  parameter int RELOCK = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             mode,
  output logic             locked,
  output logic             err,
  output logic             wrap,
  output logic             dir_chg,
  output logic [ERR_W-1:0] err_cnt,
  output logic [ERR_W-1:0] wrap_cnt
);

  typedef enum logic [1:0] {IDLE, LOCKED, RESYNC} state_t;

  localparam logic [WIDTH-1:0] ONE_W    = 1;
  localparam logic [ERR_W-1:0] ONE_E    = 1;
  localparam logic [2:0]       ONE_G    = 3'd1;
  localparam logic [2:0]       RELOCK_G = 3'(RELOCK);

  state_t           r_state;
  logic [WIDTH-1:0] r_prev;
  logic             r_mode_q;
  logic [2:0]       r_good_cnt;
  logic             r_locked;
  logic             r_err;
  logic             r_wrap;
  logic             r_dir_chg;
  logic [ERR_W-1:0] r_err_cnt;
  logic [ERR_W-1:0] r_wrap_cnt;

  logic [WIDTH-1:0] w_expected;
  logic             w_match;
  logic             w_boundary;
  logic [2:0]       w_good_inc;
  logic [ERR_W-1:0] w_err_cnt_sat;
  logic [ERR_W-1:0] w_wrap_cnt_sat;

  // Wrap arithmetic comes for free from the WIDTH-bit add/subtract.
  assign w_expected     = r_mode_q ? (r_prev + ONE_W) : (r_prev - ONE_W);
  assign w_match        = (cnt_in == w_expected);
  assign w_boundary     = r_mode_q ? (r_prev == '1) : (r_prev == '0);
  assign w_good_inc     = r_good_cnt + ONE_G;
  assign w_err_cnt_sat  = (r_err_cnt == '1) ? r_err_cnt : (r_err_cnt + ONE_E);
  assign w_wrap_cnt_sat = (r_wrap_cnt == '1) ? r_wrap_cnt : (r_wrap_cnt + ONE_E);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_prev     <= '0;
      r_mode_q   <= 1'b0;
      r_good_cnt <= '0;
      r_locked   <= 1'b0;
      r_err      <= 1'b0;
      r_wrap     <= 1'b0;
      r_dir_chg  <= 1'b0;
      r_err_cnt  <= '0;
      r_wrap_cnt <= '0;
    end else begin
      r_err     <= 1'b0;
      r_wrap    <= 1'b0;
      r_dir_chg <= 1'b0;
      if (en) begin
        r_prev   <= cnt_in;
        r_mode_q <= mode;
        case (r_state)
          IDLE: begin
            r_state    <= RESYNC;
            r_good_cnt <= '0;
            r_locked   <= 1'b0;
          end
          RESYNC: begin
            r_dir_chg <= (mode != r_mode_q);
            if (w_match) begin
              if (w_good_inc == RELOCK_G) begin
                r_state    <= LOCKED;
                r_locked   <= 1'b1;
                r_good_cnt <= '0;
              end else begin
                r_good_cnt <= w_good_inc;
              end
            end else begin
              r_good_cnt <= '0;
              r_err      <= 1'b1;
              r_err_cnt  <= w_err_cnt_sat;
            end
          end
          LOCKED: begin
            r_dir_chg <= (mode != r_mode_q);
            if (w_match) begin
              if (w_boundary) begin
                r_wrap     <= 1'b1;
                r_wrap_cnt <= w_wrap_cnt_sat;
              end
            end else begin
              r_state    <= RESYNC;
              r_locked   <= 1'b0;
              r_good_cnt <= '0;
              r_err      <= 1'b1;
              r_err_cnt  <= w_err_cnt_sat;
            end
          end
          default: begin
            r_state  <= IDLE;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign locked   = r_locked;
  assign err      = r_err;
  assign wrap     = r_wrap;
  assign dir_chg  = r_dir_chg;
  assign err_cnt  = r_err_cnt;
  assign wrap_cnt = r_wrap_cnt;

endmodule

// File: tb/tb_count_step_checker.sv
// Directed bench for count_step_checker: a vector table plus hand sequences for
// error-counter saturation and mid-operation reset.
module tb_count_step_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic [2:0] cnt_in = 3'd0;
  logic       mode = 1'b0;
  logic       locked, err, wrap, dir_chg;
  logic [7:0] err_cnt, wrap_cnt;

  int checks = 0;
  int failures = 0;

  count_step_checker #(.WIDTH(3), .ERR_W(8), .RELOCK(2)) dut (
    .clk(clk), .reset(reset), .en(en), .cnt_in(cnt_in), .mode(mode),
    .locked(locked), .err(err), .wrap(wrap), .dir_chg(dir_chg),
    .err_cnt(err_cnt), .wrap_cnt(wrap_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [2:0] cnt;
    logic       mode;
    logic       e_locked;
    logic       e_err;
    logic       e_wrap;
    logic       e_dir;
    int         e_errc;
    int         e_wrapc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic e, input int c, input logic m,
                     input logic l, input logic er, input logic w, input logic d,
                     input int ec, input int wc);
    vec_t v;
    v.rst = r; v.en = e; v.cnt = 3'(c); v.mode = m;
    v.e_locked = l; v.e_err = er; v.e_wrap = w; v.e_dir = d;
    v.e_errc = ec; v.e_wrapc = wc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%0d required=%0d", name, idx, act, exp);
    end
  endtask

  // Apply one edge of stimulus and sample 1 time unit after the edge.
  task automatic drive(input logic r, input logic e, input logic [2:0] c, input logic m);
    reset = r; en = e; cnt_in = c; mode = m;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int idx, input logic l, input logic er,
                         input logic w, input logic d, input int ec, input int wc);
    chk({tag, ".locked"},   idx, int'(locked),   int'(l));
    chk({tag, ".err"},      idx, int'(err),      int'(er));
    chk({tag, ".wrap"},     idx, int'(wrap),     int'(w));
    chk({tag, ".dir_chg"},  idx, int'(dir_chg),  int'(d));
    chk({tag, ".err_cnt"},  idx, int'(err_cnt),  ec);
    chk({tag, ".wrap_cnt"}, idx, int'(wrap_cnt), wc);
  endtask

  initial begin
    //   rst en cnt m   lk er wr dc errc wrapc
    add(1, 0, 0, 0,   0, 0, 0, 0, 0, 0);   // reset state
    add(0, 1, 0, 1,   0, 0, 0, 0, 0, 0);   // first sample: load only
    add(0, 1, 1, 1,   0, 0, 0, 0, 0, 0);
    add(0, 1, 2, 1,   1, 0, 0, 0, 0, 0);   // locked after sample of 2
    add(0, 1, 3, 1,   1, 0, 0, 0, 0, 0);
    add(0, 0, 7, 0,   1, 0, 0, 0, 0, 0);   // en=0 ignores garbage
    add(0, 1, 4, 1,   1, 0, 0, 0, 0, 0);
    add(0, 1, 5, 1,   1, 0, 0, 0, 0, 0);
    add(0, 1, 6, 1,   1, 0, 0, 0, 0, 0);
    add(0, 1, 7, 1,   1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1,   1, 0, 1, 0, 0, 1);   // up wrap 7->0
    add(0, 1, 1, 1,   1, 0, 0, 0, 0, 1);
    add(0, 1, 2, 1,   1, 0, 0, 0, 0, 1);
    add(0, 1, 3, 1,   1, 0, 0, 0, 0, 1);
    add(0, 1, 4, 1,   1, 0, 0, 0, 0, 1);
    add(0, 1, 5, 1,   1, 0, 0, 0, 0, 1);
    add(0, 1, 7, 1,   0, 1, 0, 0, 1, 1);   // skip: error, lose lock
    add(0, 1, 0, 1,   0, 0, 0, 0, 1, 1);   // RESYNC wrap: no pulse
    add(0, 1, 1, 1,   1, 0, 0, 0, 1, 1);   // relock after sample of 1
    add(0, 1, 2, 1,   1, 0, 0, 0, 1, 1);
    add(0, 1, 3, 1,   1, 0, 0, 0, 1, 1);
    add(0, 1, 4, 1,   1, 0, 0, 0, 1, 1);
    add(0, 1, 5, 0,   1, 0, 0, 1, 1, 1);   // direction change, legal
    add(0, 1, 4, 0,   1, 0, 0, 0, 1, 1);
    add(0, 1, 3, 0,   1, 0, 0, 0, 1, 1);
    add(0, 1, 2, 0,   1, 0, 0, 0, 1, 1);
    add(0, 1, 1, 0,   1, 0, 0, 0, 1, 1);
    add(0, 1, 0, 0,   1, 0, 0, 0, 1, 1);
    add(0, 1, 7, 0,   1, 0, 1, 0, 1, 2);   // down wrap 0->7
    add(0, 1, 6, 1,   1, 0, 0, 1, 1, 2);
    add(0, 1, 7, 1,   1, 0, 0, 0, 1, 2);
    add(0, 1, 0, 1,   1, 0, 1, 0, 1, 3);
    add(0, 1, 5, 0,   0, 1, 0, 1, 2, 3);   // error and dir change together
    add(0, 1, 4, 0,   0, 0, 0, 0, 2, 3);
    add(0, 1, 3, 0,   1, 0, 0, 0, 2, 3);
    add(0, 1, 0, 0,   0, 1, 0, 0, 3, 3);
    add(0, 1, 7, 0,   0, 0, 0, 0, 3, 3);   // legal down wrap in RESYNC
    add(0, 1, 6, 0,   1, 0, 0, 0, 3, 3);
    add(1, 1, 3, 1,   0, 0, 0, 0, 0, 0);   // reset wins over en
    add(0, 1, 5, 1,   0, 0, 0, 0, 0, 0);   // discontinuous first sample
    add(0, 1, 2, 1,   0, 1, 0, 0, 1, 0);
    add(0, 1, 3, 1,   0, 0, 0, 0, 1, 0);
    add(0, 1, 4, 1,   1, 0, 0, 0, 1, 0);

    @(negedge clk);
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].cnt, vecs[i].mode);
      chk_all("vec", i, vecs[i].e_locked, vecs[i].e_err, vecs[i].e_wrap,
              vecs[i].e_dir, vecs[i].e_errc, vecs[i].e_wrapc);
      $display("vec %0d rst=%0b en=%0b cnt=%0d mode=%0b -> lk=%0b err=%0b wrap=%0b dir=%0b errc=%0d wrapc=%0d",
               i, vecs[i].rst, vecs[i].en, vecs[i].cnt, vecs[i].mode,
               locked, err, wrap, dir_chg, err_cnt, wrap_cnt);
    end

    // Locked at 4 (up), err_cnt=1: hold cnt_in at 4 so every sample is an error.
    for (int i = 0; i < 300; i++) begin
      int exp_ec;
      exp_ec = (i + 2 > 255) ? 255 : i + 2;
      drive(1'b0, 1'b1, 3'd4, 1'b1);
      chk("sat.err", i, int'(err), 1);
      chk("sat.err_cnt", i, int'(err_cnt), exp_ec);
      chk("sat.locked", i, int'(locked), 0);
    end
    $display("sat done err_cnt=%0d", err_cnt);
    drive(1'b0, 1'b0, 3'd4, 1'b1);
    chk_all("sat_idle", 0, 0, 0, 0, 0, 255, 0);

    // Relock, take one wrap, then reset mid-operation.
    drive(1'b0, 1'b1, 3'd5, 1'b1);
    drive(1'b0, 1'b1, 3'd6, 1'b1);
    chk_all("relock", 0, 1, 0, 0, 0, 255, 0);
    drive(1'b0, 1'b1, 3'd7, 1'b1);
    drive(1'b0, 1'b1, 3'd0, 1'b1);
    chk_all("prewrap", 0, 1, 0, 1, 0, 255, 1);
    drive(1'b1, 1'b0, 3'd1, 1'b1);
    chk_all("midrst", 0, 0, 0, 0, 0, 0, 0);
    $display("midrst lk=%0b errc=%0d wrapc=%0d", locked, err_cnt, wrap_cnt);
    drive(1'b0, 1'b1, 3'd6, 1'b0);
    chk_all("post_rst_first", 0, 0, 0, 0, 0, 0, 0);
    drive(1'b0, 1'b1, 3'd5, 1'b0);
    drive(1'b0, 1'b1, 3'd4, 1'b0);
    chk_all("post_rst_lock", 0, 1, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
